// File: rtl/fp16_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : fp16_mul_sched
// Purpose  : Round-robin two-port scheduler around one shared iterative
//            half-precision multiplier (shift-add, truncating, FTZ).
// Revision : 1.0  initial release
// ============================================================================
module fp16_mul_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        in0_valid,
    input  logic [15:0] in0_a,
    input  logic [15:0] in0_b,
    output logic        in0_ready,
    input  logic        in1_valid,
    input  logic [15:0] in1_a,
    input  logic [15:0] in1_b,
    output logic        in1_ready,
    output logic        out_valid,
    output logic [15:0] out_result,
    output logic        out_tag,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_rr;
    logic        r_tag;
    logic        r_out_valid;
    logic [3:0]  r_cnt;
    logic [21:0] r_acc;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_result;

    logic        w_idle;
    logic        w_grant;
    logic [21:0] w_ma;
    logic [10:0] w_mb;
    logic        w_mb_bit;
    logic [6:0]  w_e_base;
    logic [6:0]  w_e;
    logic [9:0]  w_frac;
    logic        w_sign;
    logic        w_zero_op;
    logic [15:0] w_result;

    assign w_idle    = (r_state == S_IDLE);
    assign in0_ready = w_idle & in0_valid & (~in1_valid | ~r_rr);
    assign in1_ready = w_idle & in1_valid & (~in0_valid |  r_rr);
    assign w_grant   = in0_ready | in1_ready;

    // One partial product per MUL cycle, selected by the iteration count.
    assign w_ma     = {11'd0, 1'b1, r_a[9:0]} << r_cnt;
    assign w_mb     = {1'b1, r_b[9:0]};
    assign w_mb_bit = |(w_mb & (11'd1 << r_cnt));

    // Exponent kept 7-bit two's complement so underflow shows as <= 0.
    assign w_e_base  = {2'b00, r_a[14:10]} + {2'b00, r_b[14:10]} - 7'd15;
    assign w_e       = w_e_base + {6'd0, r_acc[21]};
    assign w_frac    = r_acc[21] ? r_acc[20:11] : r_acc[19:10];
    assign w_sign    = r_a[15] ^ r_b[15];
    assign w_zero_op = (r_a[14:10] == 5'd0) | (r_b[14:10] == 5'd0);

    always_comb begin
        w_result = {w_sign, w_e[4:0], w_frac};
        if (w_zero_op) begin
            w_result = {w_sign, 15'd0};
        end else if ($signed(w_e) >= 7'sd31) begin
            w_result = {w_sign, 5'h1F, 10'd0};
        end else if ($signed(w_e) <= 7'sd0) begin
            w_result = {w_sign, 15'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr        <= 1'b0;
            r_tag       <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= 4'd0;
            r_acc       <= 22'd0;
            r_a         <= 16'd0;
            r_b         <= 16'd0;
            r_result    <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_a     <= in0_ready ? in0_a : in1_a;
                        r_b     <= in0_ready ? in0_b : in1_b;
                        r_tag   <= in1_ready;
                        r_rr    <= in0_ready;
                        r_cnt   <= 4'd0;
                        r_acc   <= 22'd0;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (w_mb_bit) begin
                        r_acc <= r_acc + w_ma;
                    end
                    if (r_cnt == 4'd10) begin
                        r_state <= S_NORM;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_NORM: begin
                    r_result    <= w_result;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_tag    = r_tag;
    assign busy       = ~w_idle;

endmodule
`default_nettype wire

// File: doc/fp16_mul_sched.md
# fp16_mul_sched

Two-requester scheduler and sequencer for the half-precision (1/5/10, bias 15) floating-point multiply datapath. It arbitrates round-robin between two operand sources and runs one iterative 11x11 shift-add mantissa multiply at a time. It then normalizes, packs and holds the result until the consumer accepts it. It sits between the operand producers and any downstream accumulator, replacing per-requester combinational multipliers with one shared sequential unit.

## Interface
- No parameters. Format is fixed at 16 bits: sign [15], exponent [14:10], fraction [9:0].
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- in0_valid  in  1  requester 0 has an operand pair.
- in0_a, in0_b  in  16 each  requester 0 operands.
- in0_ready  out  1  requester 0 pair is accepted this cycle.
- in1_valid, in1_a, in1_b, in1_ready  same as port 0, for requester 1.
- out_valid  out  1  result available.
- out_result  out  16  packed product.
- out_tag  out  1  index of the requester that owns out_result.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, MUL, NORM, DONE.
- **IDLE**
  - in0_ready = in0_valid & (!in1_valid | rr==0).
  - in1_ready = in1_valid & (!in0_valid | rr==1).
  - A handshake latches a, b and tag, sets rr to the opposite of the granted port, clears the counter and the 22-bit accumulator, and moves to MUL.
  - Neither in*_ready is asserted outside IDLE.
- **MUL**: 11 iterations, counter 0..10.
  - Multiplicand ma = {1,frac_a}, zero-extended to 22 bits and shifted left by the counter value.
  - If bit[counter] of mb = {1,frac_b} is set, add ma to the accumulator.
  - After count 10, go to NORM.
- **NORM**: one cycle.
  - Sign = a[15]^b[15].
  - Exponent is a 7-bit signed value: e = exp_a + exp_b - 15.
  - If prod[21]: frac = prod[20:11], e = e+1. Otherwise frac = prod[19:10].
  - Rounding is truncation.
  - Result selection, in priority order:
    - Either operand exponent == 0 (zero/subnormal flushed): result {sign,15'b0}.
    - Else e >= 31: result {sign,5'h1F,10'b0} (infinity).
    - Else e <= 0: result {sign,15'b0}.
    - Else: result {sign,e[4:0],frac}.
  - Operands with exponent 31 are treated as ordinary numbers. There is no NaN handling.
  - Go to DONE.
- **DONE**
  - out_valid = 1. out_result and out_tag are stable.
  - When out_ready = 1, go to IDLE.
- rr is the round-robin pointer. After reset it favours port 0.
- A single valid requester is always granted, regardless of rr.

## Timing
- Reset values:
  - out_valid = 0, out_result = 0, out_tag = 0, busy = 0.
  - in0_ready = in1_ready = 0, except as combinationally enabled in IDLE.
  - rr = 0, state = IDLE, counter = 0, accumulator = 0.
- Latency is fixed and data-independent. The zero and overflow cases also use the full path.
  - Handshake at edge T.
  - MUL occupies cycles T+1..T+11.
  - NORM occupies T+12.
  - out_valid is first high in cycle T+13.
- The out handshake at edge U returns the FSM to IDLE in cycle U+1. The earliest new grant is at edge U+1.
- Minimum initiation interval is 14 cycles.
- Back-pressure: out_ready may stay low indefinitely. out_result and out_tag must not change while out_valid=1.
- Simultaneous valids: exactly one ready is asserted. The loser keeps its valid high and is granted at the next IDLE.
- Requesters must hold valid and data until ready. Dropping valid before ready is legal and simply removes the request.
- rst asserted in any state aborts the operation without producing a result. The next cycle shows reset values, and no pending grant survives.

## Test plan
- 0x3E00 (1.5) × 0x4000 (2.0) on port 0 -> out_result 0x4200, out_tag 0, out_valid exactly 13 cycles after the handshake.
- Normalization and sign cases on port 1:
  - 0x3E00 × 0x3E00 -> 0x4080 (2.25, prod[21] path).
  - 0xC000 × 0x4200 -> 0xC600 (-6.0), out_tag 1.
- Special values:
  - 0x7800 × 0x7800 -> 0x7C00.
  - 0x0000 × 0x4200 -> 0x0000.
  - 0x8000 × 0x4200 -> 0x8000.
  - 0x0400 × 0x0400 -> 0x0000 (underflow).
- Both ports valid continuously from reset:
  - Grants alternate 0,1,0,1.
  - out_tag sequence is 0,1,0,1.
  - in0_ready and in1_ready are never high together.
- Hold out_ready low for 5 cycles in DONE: out_valid, out_result and out_tag stay constant, and no in*_ready asserts. Release it: IDLE in the next cycle.
- Assert rst at MUL count 5: the next cycle shows busy=0, out_valid=0 and rr=0, and no result is ever emitted for the aborted pair.
